// File: rtl/savestates_coproc.sv
// Savestate coprocessor support: traps the coprocessor into the savestate
// handler, shadows write-only registers for both CPUs and exposes them
// through the $C0 savestate window.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | coprocessor running normally
// ST_TRAPPED  | coprocessor fetched a trap vector during a savestate
// ST_RTI_PEND | handler return fetch seen, waiting for strobe release
module savestates_coproc #(
    parameter int          NREG      = 32,
    parameter logic [31:0] SNS_WMASK = 32'h0000_0079,
    parameter logic [31:0] COP_WMASK = 32'h0000_0400,
    parameter logic [7:0]  RST0      = 8'h20,
    parameter logic [23:0] TRAP_VEC0 = 24'h00FFEA,
    parameter logic [23:0] TRAP_VEC1 = 24'h00FFFC,
    parameter logic [23:0] RTI_ADDR  = 24'h008008,
    parameter int          TO_W      = 20,
    parameter int          ROM_AW    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              active,
    input  logic              ss_busy,
    input  logic              save_en,
    input  logic              ss_reg_sel,
    input  logic [23:0]       ca,
    input  logic              cpurd_n,
    input  logic              cpuwr_n,
    input  logic [7:0]        di,
    input  logic [23:0]       cop_a,
    input  logic              cop_rd_n,
    input  logic              cop_wr_n,
    input  logic [7:0]        cop_di,
    input  logic              cop_romsel,
    input  logic              sns_romsel,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_ovr,
    output logic              cop_ss_busy,
    output logic [7:0]        ss_do,
    output logic              ss_oe
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TRAPPED  = 2'd1,
        ST_RTI_PEND = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_cop_rd_n;
    logic [TO_W-1:0]   r_cnt;
    logic [TO_W-1:0]   w_cnt_inc;
    logic              r_to_flag;
    logic [7:0]        r_shadow [NREG];
    logic              r_ss_oe;
    logic [7:0]        r_ss_do;
    logic [7:0]        w_rd_data;
    logic [ROM_AW-1:0] w_rom_addr;

    // Address bits the decode never looks at; the SNES read strobe is not
    // needed because readback is driven purely by the window select.
    logic w_unused_bits;
    assign w_unused_bits = ^{ca[23], ca[21:17], cpurd_n};

    logic w_rst;
    logic w_sns_win, w_cop_win, w_sns_rsel, w_cop_rsel, w_ss_sel;
    logic w_rd_start, w_rd_end, w_is_vec, w_busy, w_to_hit, w_enter, w_to_clr;
    logic w_sk_ok, w_ck_ok, w_sm_sns, w_sm_cop, w_cm_cop;
    logic w_wr_a, w_wr_b, w_wr_c, w_wr_ab;

    assign w_rst      = ~reset_n | ~active;
    assign w_sns_win  = (ca[15:9] == 7'b0010001);
    assign w_cop_win  = (cop_a[15:9] == 7'b0010001);
    assign w_sns_rsel = ~ca[22] & w_sns_win;
    assign w_cop_rsel = ~cop_a[22] & w_cop_win;
    assign w_ss_sel   = active & ss_reg_sel & w_sns_win;

    assign w_rd_start = r_cop_rd_n & ~cop_rd_n;
    assign w_rd_end   = ~r_cop_rd_n & cop_rd_n;
    assign w_is_vec   = (cop_a == TRAP_VEC0) | (cop_a == TRAP_VEC1);
    assign w_busy     = (r_state != ST_IDLE);
    assign w_cnt_inc  = r_cnt + TO_W'(1);
    // Fire on the edge where the count becomes all-ones so the FSM leaves
    // together with the counter reaching its limit.
    assign w_to_hit   = w_busy & ((r_cnt == '1) | (w_cnt_inc == '1));
    assign w_enter    = (r_state == ST_IDLE) & (w_state_nxt == ST_TRAPPED);
    assign w_to_clr   = ~cpuwr_n & w_ss_sel & ca[8] & (ca[7:0] == 8'hFF);

    assign w_sk_ok  = ~ca[8] & (ca[7:0] < 8'(NREG));
    assign w_ck_ok  = ~cop_a[8] & (cop_a[7:0] < 8'(NREG));
    assign w_sm_sns = SNS_WMASK[ca[4:0]];
    assign w_sm_cop = COP_WMASK[ca[4:0]];
    assign w_cm_cop = COP_WMASK[cop_a[4:0]];

    assign w_wr_a  = ~cpuwr_n & w_ss_sel & w_sk_ok & (w_sm_sns | w_sm_cop);
    assign w_wr_b  = ~cpuwr_n & w_sns_rsel & w_sk_ok & ~(ss_busy & save_en) & w_sm_sns;
    assign w_wr_c  = ~cop_wr_n & w_cop_rsel & w_ck_ok & ~(w_busy & save_en) & w_cm_cop;
    // Window and SNES paths share the SNES bus, so they always target the
    // same offset with the same data and can be merged.
    assign w_wr_ab = w_wr_a | w_wr_b;

    // Coprocessor read strobe history for edge detection
    always_ff @(posedge clk) begin
        if (w_rst) r_cop_rd_n <= 1'b1;
        else       r_cop_rd_n <= cop_rd_n;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (w_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next-state; ss_busy loss and timeout override every other exit
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_start & ss_busy & w_is_vec) w_state_nxt = ST_TRAPPED;
            end
            ST_TRAPPED: begin
                if (~ss_busy | w_to_hit)                        w_state_nxt = ST_IDLE;
                else if (w_rd_start & (cop_a == RTI_ADDR))      w_state_nxt = ST_RTI_PEND;
            end
            ST_RTI_PEND: begin
                if (~ss_busy | w_to_hit | w_rd_end) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Trap timeout counter, restarted on each trap entry
    always_ff @(posedge clk) begin
        if (w_rst)                        r_cnt <= '0;
        else if (w_enter)                 r_cnt <= '0;
        else if (w_busy & (r_cnt != '1))  r_cnt <= w_cnt_inc;
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (w_rst)         r_to_flag <= 1'b0;
        else if (w_to_hit) r_to_flag <= 1'b1;
        else if (w_to_clr) r_to_flag <= 1'b0;
    end

    // Shadow registers; SNES-side writes beat coprocessor writes on one offset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (w_rst) begin
                r_shadow[i] <= (i == 0) ? RST0 : 8'h00;
            end else if (w_wr_ab && (ca[4:0] == 5'(i))) begin
                r_shadow[i] <= di;
            end else if (w_wr_c && (cop_a[4:0] == 5'(i))) begin
                r_shadow[i] <= cop_di;
            end
        end
    end

    // Readback mux: shadowed offsets, status at $1FF, zero elsewhere
    always_comb begin
        w_rd_data = 8'h00;
        if (active) begin
            if (w_sk_ok & (w_sm_sns | w_sm_cop))
                w_rd_data = r_shadow[ca[4:0]];
            else if (ca[8] & (ca[7:0] == 8'hFF))
                w_rd_data = {r_to_flag, 5'd0, r_state};
        end
    end

    // Registered readback, one cycle behind the window select
    always_ff @(posedge clk) begin
        r_ss_oe <= w_ss_sel;
        r_ss_do <= w_rd_data;
    end

    // Handler ROM address follows whichever CPU is fetching ROM
    always_comb begin
        w_rom_addr = '0;
        if (active) begin
            if (cop_romsel) w_rom_addr = {cop_a[16], cop_a[ROM_AW-2:0]};
            else            w_rom_addr = {ca[16], ca[ROM_AW-2:0]};
        end
    end

    assign rom_addr    = w_rom_addr;
    assign rom_ovr     = active & ((ss_busy & sns_romsel) | (w_busy & cop_romsel));
    assign cop_ss_busy = w_busy;
    assign ss_oe       = r_ss_oe;
    assign ss_do       = r_ss_do;

endmodule

// File: tb/tb_savestates_coproc.sv
// Directed bench for savestates_coproc with a cycle-level reference model.
module tb_savestates_coproc;

    localparam int TO_W   = 4;
    localparam int TO_LIM = (1 << TO_W) - 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0, active = 1'b1, ss_busy = 1'b0, save_en = 1'b0;
    logic        ss_reg_sel = 1'b0;
    logic [23:0] ca = 24'h0;
    logic        cpurd_n = 1'b1, cpuwr_n = 1'b1;
    logic [7:0]  di = 8'h0;
    logic [23:0] cop_a = 24'h0;
    logic        cop_rd_n = 1'b1, cop_wr_n = 1'b1;
    logic [7:0]  cop_di = 8'h0;
    logic        cop_romsel = 1'b0, sns_romsel = 1'b0;
    logic [15:0] rom_addr;
    logic        rom_ovr, cop_ss_busy, ss_oe;
    logic [7:0]  ss_do;

    savestates_coproc #(.TO_W(TO_W)) dut (
        .clk(clk), .reset_n(reset_n), .active(active), .ss_busy(ss_busy),
        .save_en(save_en), .ss_reg_sel(ss_reg_sel), .ca(ca), .cpurd_n(cpurd_n),
        .cpuwr_n(cpuwr_n), .di(di), .cop_a(cop_a), .cop_rd_n(cop_rd_n),
        .cop_wr_n(cop_wr_n), .cop_di(cop_di), .cop_romsel(cop_romsel),
        .sns_romsel(sns_romsel), .rom_addr(rom_addr), .rom_ovr(rom_ovr),
        .cop_ss_busy(cop_ss_busy), .ss_do(ss_do), .ss_oe(ss_oe)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] snsm = 32'h0000_0079;
    logic [31:0] copm = 32'h0000_0400;
    int          m_st = 0;          // 0 idle, 1 trapped, 2 return pending
    int          m_age = 0;         // clock edges spent trapped since entry
    bit          m_flag = 1'b0;
    bit          m_rdp = 1'b1;
    logic [7:0]  m_sh [32];
    logic        m_oe = 1'b0;
    logic [7:0]  m_do = 8'h0;

    function automatic bit win(input logic [23:0] a);
        return a[15:9] == 7'b0010001;
    endfunction

    always @(posedge clk) begin : model
        bit rst, sel, rs, re, to;
        int nst;
        rst = !reset_n || !active;
        sel = active && ss_reg_sel && win(ca);
        m_oe = sel;
        m_do = 8'h00;
        if (active) begin
            if (!ca[8] && ca[7:0] < 8'd32 && (snsm[ca[4:0]] || copm[ca[4:0]]))
                m_do = m_sh[ca[4:0]];
            else if (ca[8:0] == 9'h1FF)
                m_do = {m_flag, 5'b0, 2'(m_st)};
        end
        if (rst) begin
            m_st = 0; m_age = 0; m_flag = 1'b0; m_rdp = 1'b1;
            for (int i = 0; i < 32; i++) m_sh[i] = (i == 0) ? 8'h20 : 8'h00;
        end else begin
            rs = m_rdp && !cop_rd_n;
            re = !m_rdp && cop_rd_n;
            // apply lowest priority first so higher-priority writers overwrite
            if (!cop_wr_n && !cop_a[22] && win(cop_a) && !cop_a[8] && cop_a[7:0] < 8'd32
                && copm[cop_a[4:0]] && !(m_st != 0 && save_en))
                m_sh[cop_a[4:0]] = cop_di;
            if (!cpuwr_n && !ca[22] && win(ca) && !ca[8] && ca[7:0] < 8'd32
                && snsm[ca[4:0]] && !(ss_busy && save_en))
                m_sh[ca[4:0]] = di;
            if (!cpuwr_n && sel && !ca[8] && ca[7:0] < 8'd32 && (snsm[ca[4:0]] || copm[ca[4:0]]))
                m_sh[ca[4:0]] = di;
            to = 1'b0;
            if (m_st != 0) begin
                m_age++;
                if (m_age == TO_LIM) to = 1'b1;
            end
            nst = m_st;
            if (m_st == 0) begin
                if (rs && ss_busy && (cop_a == 24'h00FFEA || cop_a == 24'h00FFFC)) begin
                    nst = 1; m_age = 0;
                end
            end else if (!ss_busy || to) nst = 0;
            else if (m_st == 1 && rs && cop_a == 24'h008008) nst = 2;
            else if (m_st == 2 && re) nst = 0;
            if (to) m_flag = 1'b1;
            else if (!cpuwr_n && sel && ca[8:0] == 9'h1FF) m_flag = 1'b0;
            m_st = nst;
            m_rdp = cop_rd_n;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [15:0] ea;
        if (chk_en) begin
            ea = 16'h0;
            if (active) ea = cop_romsel ? {cop_a[16], cop_a[14:0]} : {ca[16], ca[14:0]};
            chk("cyc busy", cop_ss_busy, m_st != 0);
            chk("cyc rom_ovr", rom_ovr, active && ((ss_busy && sns_romsel) || (m_st != 0 && cop_romsel)));
            chk("cyc rom_addr", rom_addr, ea);
            chk("cyc ss_oe", ss_oe, m_oe);
            chk("cyc ss_do", ss_do, m_do);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rd_ss(input logic [8:0] off, input logic [7:0] exp, input string name);
        ca = {8'hC0, 7'b0010001, off};
        ss_reg_sel = 1'b1;
        tick();
        chk(name, ss_do, exp);
        chk({name, " oe"}, ss_oe, 1'b1);
        ss_reg_sel = 1'b0;
        ca = 24'h0;
    endtask

    task automatic sns_wr(input logic [23:0] a, input logic [7:0] d);
        ca = a; di = d; cpuwr_n = 1'b0;
        tick();
        cpuwr_n = 1'b1; ca = 24'h0;
    endtask

    task automatic trap_in(input logic [23:0] vec);
        cop_a = vec; cop_rd_n = 1'b0;
        tick();
        cop_rd_n = 1'b1;
    endtask

    initial begin
        // reset
        tick(); tick();
        chk_en = 1'b1;
        reset_n = 1'b1;
        chk("rst busy", cop_ss_busy, 1'b0);
        rd_ss(9'h000, 8'h20, "rst $00");
        rd_ss(9'h1FF, 8'h00, "rst status");

        // SNES ROM address path
        sns_romsel = 1'b1; ss_busy = 1'b1; ca = 24'h018123;
        #1;
        chk("sns rom_addr", rom_addr, 16'h8123);
        chk("sns rom_ovr", rom_ovr, 1'b1);
        tick();
        sns_romsel = 1'b0; ss_busy = 1'b0; ca = 24'h0;

        // normal trap and return
        ss_busy = 1'b1; cop_romsel = 1'b1; cop_a = 24'h00FFEA;
        #1;
        chk("idle rom_ovr", rom_ovr, 1'b0);
        chk("cop rom_addr", rom_addr, 16'h7FEA);
        trap_in(24'h00FFEA);
        chk("trap busy", cop_ss_busy, 1'b1);
        chk("trap rom_ovr", rom_ovr, 1'b1);
        cop_romsel = 1'b0;
        tick();
        chk("trap nosel ovr", rom_ovr, 1'b0);
        rd_ss(9'h1FF, 8'h01, "trapped status");
        cop_a = 24'h008008; cop_rd_n = 1'b0;
        tick();
        chk("rti busy", cop_ss_busy, 1'b1);
        rd_ss(9'h1FF, 8'h02, "rti status");
        cop_rd_n = 1'b1;
        tick();
        chk("rti done busy", cop_ss_busy, 1'b0);
        ss_busy = 1'b0;

        // save gating
        ss_busy = 1'b1; save_en = 1'b1;
        sns_wr(24'h002203, 8'h5A);
        rd_ss(9'h003, 8'h00, "save gated");
        ss_busy = 1'b0;
        sns_wr(24'h002203, 8'h5A);
        rd_ss(9'h003, 8'h5A, "ungated");
        save_en = 1'b0;

        // write priority
        ca = 24'h002200; ss_reg_sel = 1'b1; di = 8'h11; cpuwr_n = 1'b0;
        cop_a = 24'h002200; cop_di = 8'h22; cop_wr_n = 1'b0;
        tick();
        cpuwr_n = 1'b1; cop_wr_n = 1'b1; ss_reg_sel = 1'b0;
        rd_ss(9'h000, 8'h11, "prio $00");
        ca = 24'h00220A; di = 8'h33; cpuwr_n = 1'b0;
        cop_a = 24'h00220A; cop_di = 8'h44; cop_wr_n = 1'b0;
        tick();
        cpuwr_n = 1'b1; cop_wr_n = 1'b1;
        rd_ss(9'h00A, 8'h44, "masked $0A");
        ca = 24'hC0220A; ss_reg_sel = 1'b1; di = 8'h55; cpuwr_n = 1'b0;
        cop_a = 24'h00220A; cop_di = 8'h66; cop_wr_n = 1'b0;
        tick();
        cpuwr_n = 1'b1; cop_wr_n = 1'b1; ss_reg_sel = 1'b0;
        rd_ss(9'h00A, 8'h55, "ss over cop");
        ca = 24'h002204; di = 8'h77; cpuwr_n = 1'b0;
        cop_a = 24'h00220A; cop_di = 8'h88; cop_wr_n = 1'b0;
        tick();
        cpuwr_n = 1'b1; cop_wr_n = 1'b1;
        rd_ss(9'h004, 8'h77, "dual $04");
        rd_ss(9'h00A, 8'h88, "dual $0A");

        // timeout
        ss_busy = 1'b1;
        trap_in(24'h00FFFC);
        repeat (TO_LIM - 1) tick();
        chk("pre timeout busy", cop_ss_busy, 1'b1);
        tick();
        chk("timeout busy", cop_ss_busy, 1'b0);
        rd_ss(9'h1FF, 8'h80, "timeout flag");
        ca = 24'hC023FF; ss_reg_sel = 1'b1; cpuwr_n = 1'b0;
        tick();
        cpuwr_n = 1'b1;
        tick();
        chk("flag cleared", ss_do, 8'h00);
        ss_reg_sel = 1'b0; ca = 24'h0;

        // timeout and clear in the same cycle: set wins
        trap_in(24'h00FFEA);
        repeat (TO_LIM - 1) tick();
        ca = 24'hC023FF; ss_reg_sel = 1'b1; cpuwr_n = 1'b0;
        tick();
        cpuwr_n = 1'b1;
        tick();
        chk("set beats clear", ss_do, 8'h80);
        cpuwr_n = 1'b0;
        tick();
        cpuwr_n = 1'b1;
        tick();
        chk("flag cleared 2", ss_do, 8'h00);
        ss_reg_sel = 1'b0; ca = 24'h0;

        // ss_busy drop together with read end
        trap_in(24'h00FFEA);
        tick();
        cop_a = 24'h008008; cop_rd_n = 1'b0;
        tick();
        chk("abort pre busy", cop_ss_busy, 1'b1);
        cop_rd_n = 1'b1; ss_busy = 1'b0;
        tick();
        chk("abort busy", cop_ss_busy, 1'b0);
        rd_ss(9'h1FF, 8'h00, "abort status");

        // ss_busy drop while trapped
        ss_busy = 1'b1;
        trap_in(24'h00FFFC);
        ss_busy = 1'b0;
        tick();
        chk("trap abort busy", cop_ss_busy, 1'b0);

        // reset mid-trap
        ss_busy = 1'b1;
        trap_in(24'h00FFEA);
        chk("pre rst busy", cop_ss_busy, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("mid-trap rst busy", cop_ss_busy, 1'b0);
        reset_n = 1'b1;
        rd_ss(9'h000, 8'h20, "post rst $00");
        rd_ss(9'h00A, 8'h00, "post rst $0A");

        // inactive block
        active = 1'b0; cop_romsel = 1'b1; sns_romsel = 1'b1;
        cop_a = 24'h00FFEA; ca = 24'hC02200; ss_reg_sel = 1'b1;
        #1;
        chk("inactive rom_addr", rom_addr, 16'h0000);
        chk("inactive rom_ovr", rom_ovr, 1'b0);
        tick();
        chk("inactive ss_oe", ss_oe, 1'b0);
        chk("inactive ss_do", ss_do, 8'h00);
        active = 1'b1; cop_romsel = 1'b0; sns_romsel = 1'b0; ss_reg_sel = 1'b0;
        ss_busy = 1'b0; ca = 24'h0; cop_a = 24'h0;
        tick(); tick();

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
